// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side handshake bundle for icache_responder.
interface icache_responder_if;
  logic        req_rd_i;
  logic [31:0] req_pc_i;
  logic        req_flush_i;
  logic        req_invalidate_i;
  logic        req_accept_o;
  logic        req_valid_o;
  logic        req_error_o;
  logic [31:0] req_inst_o;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic        mem_accept_i;
  logic        mem_valid_i;
  logic        mem_error_i;
  logic [31:0] mem_data_i;

  // Cache side
  modport slave (
    input  req_rd_i, req_pc_i, req_flush_i, req_invalidate_i,
    input  mem_accept_i, mem_valid_i, mem_error_i, mem_data_i,
    output req_accept_o, req_valid_o, req_error_o, req_inst_o,
    output mem_rd_o, mem_addr_o
  );

  // Fetch unit / memory side
  modport master (
    output req_rd_i, req_pc_i, req_flush_i, req_invalidate_i,
    output mem_accept_i, mem_valid_i, mem_error_i, mem_data_i,
    input  req_accept_o, req_valid_o, req_error_o, req_inst_o,
    input  mem_rd_o, mem_addr_o
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache with single-word refill.
module icache_responder #(
  parameter int unsigned LINES        = 16,
  parameter logic [31:0] MEM_ERR_INST = 32'h53
) (
  input  logic             clk_i,
  input  logic             rst_i,
  icache_responder_if.slave bus
);

  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAGW = 30 - IDX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL_REQ,
    S_REFILL_WAIT
  } state_t;

  state_t            r_state;
  logic [LINES-1:0]  r_valid;
  logic [TAGW-1:0]   r_tag  [LINES];
  logic [31:0]       r_data [LINES];
  logic [31:2]       r_pc;
  logic              r_flush_pending;
  logic              r_req_valid;
  logic              r_req_error;
  logic [31:0]       r_req_inst;
  logic              r_mem_rd;
  logic [31:0]       r_mem_addr;

  logic [IDX-1:0]    w_idx;
  logic [TAGW-1:0]   w_tag;
  logic [IDX-1:0]    w_fidx;
  logic              w_flush;
  logic              w_accept;
  logic              w_hit;
  logic              w_fill;

  // Address decode, hit detection and refill-write qualification
  always_comb begin
    w_idx    = bus.req_pc_i[IDX+1:2];
    w_tag    = bus.req_pc_i[31:IDX+2];
    w_fidx   = r_pc[IDX+1:2];
    w_flush  = bus.req_flush_i | bus.req_invalidate_i;
    w_accept = (r_state == S_IDLE) && bus.req_rd_i && !w_flush && !r_flush_pending;
    w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // A flush arriving in the same cycle as the refill data also suppresses the write
    w_fill   = !rst_i && (r_state == S_REFILL_WAIT) && bus.mem_valid_i &&
               !bus.mem_error_i && !r_flush_pending && !w_flush;
  end

  // Control FSM, valid bits and registered response/refill outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= S_IDLE;
      r_valid         <= '0;
      r_flush_pending <= 1'b0;
      r_pc            <= '0;
      r_req_valid     <= 1'b0;
      r_req_error     <= 1'b0;
      r_req_inst      <= '0;
      r_mem_rd        <= 1'b0;
      r_mem_addr      <= '0;
    end else begin
      r_req_valid <= 1'b0;
      r_req_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_flush) begin
            r_valid <= '0;
          end else if (w_accept) begin
            if (bus.req_pc_i[1:0] != 2'b00) begin
              r_req_valid <= 1'b1;
              r_req_error <= 1'b1;
              r_req_inst  <= MEM_ERR_INST;
            end else if (w_hit) begin
              r_req_valid <= 1'b1;
              r_req_inst  <= r_data[w_idx];
            end else begin
              r_pc       <= bus.req_pc_i[31:2];
              r_mem_rd   <= 1'b1;
              r_mem_addr <= {bus.req_pc_i[31:2], 2'b00};
              r_state    <= S_REFILL_REQ;
            end
          end
        end
        S_REFILL_REQ: begin
          if (w_flush) r_flush_pending <= 1'b1;
          if (bus.mem_accept_i) begin
            r_mem_rd <= 1'b0;
            r_state  <= S_REFILL_WAIT;
          end
        end
        S_REFILL_WAIT: begin
          if (bus.mem_valid_i) begin
            r_req_valid <= 1'b1;
            r_req_error <= bus.mem_error_i;
            r_req_inst  <= bus.mem_error_i ? MEM_ERR_INST : bus.mem_data_i;
            r_state     <= S_IDLE;
            if (r_flush_pending || w_flush) begin
              r_valid         <= '0;
              r_flush_pending <= 1'b0;
            end else if (!bus.mem_error_i) begin
              r_valid[w_fidx] <= 1'b1;
            end
          end else if (w_flush) begin
            r_flush_pending <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage; only valid bits need reset
  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_tag[w_fidx]  <= r_pc[31:IDX+2];
      r_data[w_fidx] <= bus.mem_data_i;
    end
  end

  assign bus.req_accept_o = w_accept;
  assign bus.req_valid_o  = r_req_valid;
  assign bus.req_error_o  = r_req_error;
  assign bus.req_inst_o   = r_req_inst;
  assign bus.mem_rd_o     = r_mem_rd;
  assign bus.mem_addr_o   = r_mem_addr;

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios then random fetches,
// compared against a word-address lookup table model.
module tb_icache_responder;

  localparam int unsigned LINES = 16;
  localparam logic [31:0] ERR_INST = 32'h53;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  // Reference model: per-line valid flag, full word address and data
  bit          mvalid [LINES];
  logic [29:0] maddr  [LINES];
  logic [31:0] mdata  [LINES];

  icache_responder_if bus ();

  icache_responder #(.LINES(LINES), .MEM_ERR_INST(ERR_INST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  // One fetch, serviced to completion; fl injects a flush/invalidate during the refill
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input bit merr, input bit fl);
    int unsigned idx;
    bit          hit;
    idx = (pc >> 2) % LINES;
    hit = mvalid[idx] && (maddr[idx] == pc[31:2]);
    @(negedge clk);
    bus.req_rd_i = 1'b1;
    bus.req_pc_i = pc;
    #1;
    chk("accept", {31'd0, bus.req_accept_o}, 32'd1);
    @(negedge clk);
    bus.req_rd_i = 1'b0;
    bus.req_pc_i = $urandom;
    if (pc[1:0] != 2'b00) begin
      chk("misal_valid", {31'd0, bus.req_valid_o}, 32'd1);
      chk("misal_err",   {31'd0, bus.req_error_o}, 32'd1);
      chk("misal_inst",  bus.req_inst_o, ERR_INST);
      chk("misal_memrd", {31'd0, bus.mem_rd_o}, 32'd0);
    end else if (hit) begin
      chk("hit_valid", {31'd0, bus.req_valid_o}, 32'd1);
      chk("hit_err",   {31'd0, bus.req_error_o}, 32'd0);
      chk("hit_inst",  bus.req_inst_o, mdata[idx]);
      chk("hit_memrd", {31'd0, bus.mem_rd_o}, 32'd0);
    end else begin
      chk("miss_novalid", {31'd0, bus.req_valid_o}, 32'd0);
      chk("miss_memrd",   {31'd0, bus.mem_rd_o}, 32'd1);
      chk("miss_addr",    bus.mem_addr_o, {pc[31:2], 2'b00});
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("memrd_hold", {31'd0, bus.mem_rd_o}, 32'd1);
      end
      bus.mem_accept_i = 1'b1;
      @(negedge clk);
      bus.mem_accept_i = 1'b0;
      chk("memrd_drop", {31'd0, bus.mem_rd_o}, 32'd0);
      if (fl) begin
        if ($urandom_range(0, 1) == 0) bus.req_flush_i = 1'b1;
        else bus.req_invalidate_i = 1'b1;
        @(negedge clk);
        bus.req_flush_i      = 1'b0;
        bus.req_invalidate_i = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("wait_novalid", {31'd0, bus.req_valid_o}, 32'd0);
      end
      bus.mem_valid_i = 1'b1;
      bus.mem_error_i = merr;
      bus.mem_data_i  = data;
      @(negedge clk);
      bus.mem_valid_i = 1'b0;
      bus.mem_error_i = 1'b0;
      bus.mem_data_i  = $urandom;
      chk("refill_valid", {31'd0, bus.req_valid_o}, 32'd1);
      chk("refill_err",   {31'd0, bus.req_error_o}, {31'd0, merr});
      chk("refill_inst",  bus.req_inst_o, merr ? ERR_INST : data);
      if (fl) model_clear();
      else if (!merr) begin
        mvalid[idx] = 1'b1;
        maddr[idx]  = pc[31:2];
        mdata[idx]  = data;
      end
    end
    @(negedge clk);
    chk("valid_single", {31'd0, bus.req_valid_o}, 32'd0);
  endtask

  // Flush (or invalidate) in IDLE with a competing request that must not be accepted
  task automatic idle_flush(input bit inval);
    @(negedge clk);
    bus.req_rd_i = 1'b1;
    bus.req_pc_i = 32'h104;
    if (inval) bus.req_invalidate_i = 1'b1;
    else bus.req_flush_i = 1'b1;
    #1;
    chk("flush_noaccept", {31'd0, bus.req_accept_o}, 32'd0);
    @(negedge clk);
    bus.req_rd_i         = 1'b0;
    bus.req_flush_i      = 1'b0;
    bus.req_invalidate_i = 1'b0;
    chk("flush_novalid", {31'd0, bus.req_valid_o}, 32'd0);
    model_clear();
  endtask

  initial begin
    logic [31:0] pc;
    errors = 0;
    checks = 0;
    model_clear();
    rst = 1'b1;
    bus.req_rd_i = 1'b0;
    bus.req_pc_i = '0;
    bus.req_flush_i = 1'b0;
    bus.req_invalidate_i = 1'b0;
    bus.mem_accept_i = 1'b0;
    bus.mem_valid_i = 1'b0;
    bus.mem_error_i = 1'b0;
    bus.mem_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, bus.req_valid_o}, 32'd0);
    chk("rst_err",   {31'd0, bus.req_error_o}, 32'd0);
    chk("rst_inst",  bus.req_inst_o, 32'd0);
    chk("rst_memrd", {31'd0, bus.mem_rd_o}, 32'd0);
    chk("rst_addr",  bus.mem_addr_o, 32'd0);
    rst = 1'b0;

    // Cold miss then hit
    fetch(32'h100, 32'h00500093, 1'b0, 1'b0);
    fetch(32'h100, 32'h0, 1'b0, 1'b0);
    // Conflict on line 0
    fetch(32'h140, 32'h11111111, 1'b0, 1'b0);
    fetch(32'h100, 32'h00500093, 1'b0, 1'b0);
    // Misaligned
    fetch(32'h102, 32'h0, 1'b0, 1'b0);
    // Bus error, then the same address misses again
    fetch(32'h200, 32'hDEADBEEF, 1'b1, 1'b0);
    fetch(32'h200, 32'h22222222, 1'b0, 1'b0);
    // Flush during refill: data returned, everything invalid afterwards
    fetch(32'h100, 32'h00500093, 1'b0, 1'b0);
    fetch(32'h104, 32'h33333333, 1'b0, 1'b0);
    fetch(32'h300, 32'h44444444, 1'b0, 1'b1);
    fetch(32'h300, 32'h55555555, 1'b0, 1'b0);
    fetch(32'h100, 32'h00500093, 1'b0, 1'b0);
    fetch(32'h104, 32'h66666666, 1'b0, 1'b0);
    // Flush / invalidate in IDLE
    idle_flush(1'b0);
    fetch(32'h104, 32'h77777777, 1'b0, 1'b0);
    fetch(32'h104, 32'h0, 1'b0, 1'b0);
    idle_flush(1'b1);
    fetch(32'h104, 32'h88888888, 1'b0, 1'b0);

    // Reset while in REFILL_REQ
    fetch(32'h180, 32'h99999999, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_rd_i = 1'b1;
    bus.req_pc_i = 32'h1C0;
    @(negedge clk);
    bus.req_rd_i = 1'b0;
    chk("pre_rst_memrd", {31'd0, bus.mem_rd_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_memrd", {31'd0, bus.mem_rd_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.req_valid_o}, 32'd0);
    chk("mid_rst_addr",  bus.mem_addr_o, 32'd0);
    model_clear();
    @(negedge clk);
    chk("post_rst_valid", {31'd0, bus.req_valid_o}, 32'd0);
    fetch(32'h180, 32'hAAAAAAAA, 1'b0, 1'b0);
    fetch(32'h1C0, 32'hBBBBBBBB, 1'b0, 1'b0);

    // Random fetches over a small address pool to mix hits, conflicts and errors
    for (int n = 0; n < 60; n++) begin
      pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      fetch(pc, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 19) == 0) idle_flush($urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
- REQ-001 SHALL have parameter LINES, default 16, giving the number of direct-mapped one-word lines (power of 2, 4..256).
- REQ-002 SHALL have parameter MEM_ERR_INST, default 32'h53, giving the instruction word driven with an error response.
- REQ-003 clk_i  in  1  Clock; single clock domain, all state updates on rising edge.
- REQ-004 rst_i  in  1  Reset, synchronous, active-high.
- REQ-005 req_rd_i  in  1  Fetch read request; held high until accepted.
- REQ-006 req_pc_i  in  32  Fetch address; valid while req_rd_i is high.
- REQ-007 req_flush_i  in  1  Invalidate all lines.
- REQ-008 req_invalidate_i  in  1  Invalidate all lines (same effect as flush).
- REQ-009 req_accept_o  out  1  Request accepted this cycle.
- REQ-010 req_valid_o  out  1  Response valid; one-cycle pulse.
- REQ-011 req_error_o  out  1  Response is a fault; qualified by req_valid_o.
- REQ-012 req_inst_o  out  32  Response instruction word.
- REQ-013 mem_rd_o  out  1  Refill read request to memory.
- REQ-014 mem_addr_o  out  32  Refill word address, with bits [1:0] = 0.
- REQ-015 mem_accept_i  in  1  Memory accepted mem_rd_o.
- REQ-016 mem_valid_i  in  1  Refill data valid.
- REQ-017 mem_error_i  in  1  Refill bus error; qualified by mem_valid_i.
- REQ-018 mem_data_i  in  32  Refill data.

Function
- REQ-019 The address SHALL split as index = pc[IDX+1:2] and tag = pc[31:IDX+2], where IDX = log2(LINES).
- REQ-020 The state machine SHALL have states IDLE, REFILL_REQ and REFILL_WAIT.
- REQ-021 req_accept_o SHALL be high combinationally when state==IDLE && req_rd_i && !req_flush_i && !req_invalidate_i && !flush_pending.
- REQ-022 For an accepted request with pc[1:0]!=0, the block SHALL pulse req_valid_o=1 with req_error_o=1 and req_inst_o=MEM_ERR_INST in the next cycle, with no memory access.
- REQ-023 For an accepted, aligned hit (line valid and tag equal), the block SHALL pulse req_valid_o=1 with req_error_o=0 and req_inst_o=line data in the next cycle, and stay in IDLE; hit latency is 1 cycle.
- REQ-024 For an accepted, aligned miss, the block SHALL latch the pc and move to REFILL_REQ.
- REQ-025 In REFILL_REQ, the block SHALL hold mem_rd_o=1 and mem_addr_o={pc[31:2],2'b00}, and move to REFILL_WAIT on mem_accept_i.
- REQ-026 In REFILL_WAIT with mem_valid_i && !mem_error_i, the block SHALL write data, tag and valid=1 into the line (unless REQ-030 applies), pulse the response with mem_data_i in the next cycle, and return to IDLE.
- REQ-027 In REFILL_WAIT with mem_valid_i && mem_error_i, the block SHALL leave the line unchanged, respond with error=1 and inst=MEM_ERR_INST, and return to IDLE.
- REQ-028 mem_rd_o SHALL be 0 outside REFILL_REQ, and mem_valid_i SHALL be ignored outside REFILL_WAIT.
- REQ-029 A flush or invalidate in IDLE SHALL clear all valid bits at that edge; a request presented in the same cycle is not accepted.
- REQ-030 A flush or invalidate during REFILL_* SHALL set flush_pending; the refill still returns its response but is not written; all valid bits are cleared, and flush_pending is cleared, on the edge that returns to IDLE.
- REQ-031 At most one request SHALL be outstanding; req_valid_o SHALL never be high on two consecutive cycles for one acceptance.

Reset
- REQ-032 Reset SHALL set the state to IDLE, clear all valid bits, and clear flush_pending.
- REQ-033 Reset SHALL drive req_valid_o=0, req_error_o=0, req_inst_o=0, mem_rd_o=0 and mem_addr_o=0.
- REQ-034 Reset asserted mid-refill SHALL abandon the refill, produce no response, and write no line.

Verification
- REQ-035 Cold miss: pc=0x100, memory returns 0x00500093 -> mem_rd_o/mem_addr_o=0x100, then req_valid_o=1 with inst=0x00500093; the same pc again -> hit in 1 cycle with mem_rd_o held 0.
- REQ-036 Conflict: pc=0x100 then 0x140 (LINES=16, same index) -> both miss, and 0x100 then misses again.
- REQ-037 Misaligned pc=0x102 -> next cycle valid=1, error=1, inst=0x53; mem_rd_o stays 0.
- REQ-038 Bus error: mem_error_i=1 on refill of 0x200 -> error response; a later access to 0x200 misses again.
- REQ-039 Flush during REFILL_WAIT of 0x300 -> data still returned; after return to IDLE, both 0x300 and the previously cached 0x100 miss.
- REQ-040 Reset in REFILL_REQ -> mem_rd_o=0 next cycle, no req_valid_o, and all lines miss.
